temp_entry: RTL

TEMP_ENTRY -- requirements
Module: temp_entry

---
 rtl/temp_entry.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/temp_entry.sv
// temp_entry: keypad entry of a three-digit BCD temperature reading (tens of
// degrees, degrees, tenths). Each completed entry is committed as the current
// reading, and the BCD absolute difference to the previous reading is published
// one cycle later together with a one-cycle got_value pulse.
//
// Optional feature: define TEMP_ENTRY_TIMEOUT_EN to abandon a partial entry
// after TIMEOUT_CYCLES cycles without a key_valid strobe.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   key_valid           one-cycle strobe, key_digit holds a keypad digit
//   key_digit[3:0]      BCD digit, 10-15 are illegal
//   key_clear           one-cycle strobe discarding the partial entry
//   bcd_press[2:0]      digits accepted in the current entry (0-3)
//   temp_*_value[3:0]   committed reading
//   out_*[3:0]          BCD |current - previous| reading
//   diff_read[2:0]      committed readings since reset, saturating at 2
//   got_value           one-cycle pulse, new reading and difference valid
//   entry_error         one-cycle pulse on an illegal digit or a timeout
module temp_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    output logic [2:0] bcd_press,
    output logic [3:0] temp_huns_value,
    output logic [3:0] temp_tens_value,
    output logic [3:0] temp_ones_value,
    output logic [3:0] out_huns,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones,
    output logic [2:0] diff_read,
    output logic       got_value,
    output logic       entry_error
);

    typedef enum logic [2:0] {
        StIdle,
        StDig1,
        StDig2,
        StCommit,
        StCalc
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] entry_q, entry_d;
    logic [11:0] temp_q, temp_d;
    logic [11:0] prev_q, prev_d;
    logic [11:0] out_q, out_d;
    logic [2:0]  bcd_press_q, bcd_press_d;
    logic [2:0]  diff_read_q, diff_read_d;
    logic        got_value_q, got_value_d;
    logic        entry_error_q, entry_error_d;
    logic        timeout_hit;
    logic [11:0] diff_calc;

    // |a - b| on 3-digit BCD: subtract the smaller from the larger digit by
    // digit, rippling a borrow from tenths upwards.
    function automatic logic [11:0] bcd_absdiff(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] hi;
        logic [11:0] lo;
        logic [11:0] res;
        logic        borrow;
        logic [4:0]  t;
        // BCD digit order matches numeric order, so a plain compare works.
        if (a >= b) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        borrow = 1'b0;
        res    = '0;
        for (int i = 0; i < 3; i++) begin
            t      = {1'b0, hi[4*i +: 4]} - {1'b0, lo[4*i +: 4]} - {4'b0, borrow};
            borrow = t[4];
            if (borrow) begin
                t = t + 5'd10;
            end
            res[4*i +: 4] = t[3:0];
        end
        return res;
    endfunction

    assign diff_calc = bcd_absdiff(temp_q, prev_q);

`ifdef TEMP_ENTRY_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts idle cycles inside a partial entry; any strobe or leaving the
    // digit states restarts it from zero.
    always_comb begin
        tmo_cnt_d   = '0;
        timeout_hit = 1'b0;
        if ((state_q == StDig1 || state_q == StDig2) && !key_valid && !key_clear) begin
            if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        temp_d        = temp_q;
        prev_d        = prev_q;
        out_d         = out_q;
        bcd_press_d   = bcd_press_q;
        diff_read_d   = diff_read_q;
        got_value_d   = 1'b0;
        entry_error_d = 1'b0;

        unique case (state_q)
            StIdle, StDig1, StDig2: begin
                if (key_clear) begin
                    // Clear wins over a coincident digit; no-op when idle.
                    state_d     = StIdle;
                    bcd_press_d = '0;
                end else if (key_valid) begin
                    if (key_digit > 4'd9) begin
                        entry_error_d = 1'b1;
                    end else begin
                        entry_d     = {entry_q[7:0], key_digit};
                        bcd_press_d = bcd_press_q + 3'd1;
                        if (state_q == StIdle) begin
                            state_d = StDig1;
                        end else if (state_q == StDig1) begin
                            state_d = StDig2;
                        end else begin
                            state_d = StCommit;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d       = StIdle;
                    bcd_press_d   = '0;
                    entry_error_d = 1'b1;
                end
            end
            StCommit: begin
                prev_d      = temp_q;
                temp_d      = entry_q;
                diff_read_d = (diff_read_q >= 3'd2) ? 3'd2 : diff_read_q + 3'd1;
                state_d     = StCalc;
            end
            StCalc: begin
                // The first reading after reset has nothing to compare against.
                out_d       = (diff_read_q == 3'd1) ? 12'h000 : diff_calc;
                got_value_d = 1'b1;
                bcd_press_d = '0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            entry_q       <= '0;
            temp_q        <= '0;
            prev_q        <= '0;
            out_q         <= '0;
            bcd_press_q   <= '0;
            diff_read_q   <= '0;
            got_value_q   <= 1'b0;
            entry_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            temp_q        <= temp_d;
            prev_q        <= prev_d;
            out_q         <= out_d;
            bcd_press_q   <= bcd_press_d;
            diff_read_q   <= diff_read_d;
            got_value_q   <= got_value_d;
            entry_error_q <= entry_error_d;
        end
    end

    assign bcd_press       = bcd_press_q;
    assign temp_huns_value = temp_q[11:8];
    assign temp_tens_value = temp_q[7:4];
    assign temp_ones_value = temp_q[3:0];
    assign out_huns        = out_q[11:8];
    assign out_tens        = out_q[7:4];
    assign out_ones        = out_q[3:0];
    assign diff_read       = diff_read_q;
    assign got_value       = got_value_q;
    assign entry_error     = entry_error_q;

endmodule
